// File: rtl/seq_alu.sv
// Handshaked, registered ALU with flags, shifts and an iterative
// shift-add multiplier. One operation in flight at a time.
module seq_alu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       CONTROL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZEROFLAG,
  output logic             NEGFLAG,
  output logic             CARRYFLAG,
  output logic             OVFLAG,
  output logic             ERRFLAG
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_PSB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic             alu_of;
  logic             alu_ef;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [SHW:0]     cnt;

  assign IN_READY  = (state == S_IDLE) && !RST;
  assign OUT_VALID = (state == S_DONE);
  assign accept    = IN_VALID && IN_READY;

  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    dif     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    shamt   = B[SHW-1:0];
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_ef  = 1'b0;
    case (CONTROL)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_NOR: alu_res = ~(A | B);
      OP_PSB: alu_res = B;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
        alu_of  = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_cf  = dif[WIDTH];
        alu_of  = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL: alu_res = A << shamt;
      OP_SRL: alu_res = A >> shamt;
      OP_SRA: alu_res = $unsigned($signed(A) >>> shamt);
      OP_MUL: alu_res = '0;
      default: alu_ef = 1'b1;
    endcase
  end

  // One partial product per edge; mcand walks left, mplier walks right
  assign acc_n = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept)
        state_n = (CONTROL == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (cnt == CNT_END) state_n = S_DONE;
      S_DONE: if (OUT_READY) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RESULT    <= '0;
      ZEROFLAG  <= 1'b0;
      NEGFLAG   <= 1'b0;
      CARRYFLAG <= 1'b0;
      OVFLAG    <= 1'b0;
      ERRFLAG   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (CONTROL == OP_MUL) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            RESULT    <= alu_res;
            ZEROFLAG  <= (alu_res == '0);
            NEGFLAG   <= alu_res[WIDTH-1];
            CARRYFLAG <= alu_cf;
            OVFLAG    <= alu_of;
            ERRFLAG   <= alu_ef;
          end
        end
        S_MUL: begin
          if (cnt == CNT_END) begin
            RESULT    <= acc;
            ZEROFLAG  <= (acc == '0);
            NEGFLAG   <= acc[WIDTH-1];
            CARRYFLAG <= 1'b0;
            OVFLAG    <= 1'b0;
            ERRFLAG   <= 1'b0;
          end else begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + (SHW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 64-bit and an 8-bit instance
// sharing clock and reset.
module tb_seq_alu;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        iv64, ir64, ov64, or64;
  logic [63:0] a64, b64, res64;
  logic [3:0]  c64;
  logic        zf64, nf64, cf64, of64, ef64;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  c8;
  logic        zf8, nf8, cf8, of8, ef8;
  logic [4:0]  fl8;

  int checks = 0;
  int failures = 0;

  assign fl8 = {zf8, nf8, cf8, of8, ef8};

  seq_alu #(.WIDTH(64)) d64 (
    .CLK(CLK), .RST(RST),
    .IN_VALID(iv64), .IN_READY(ir64),
    .A(a64), .B(b64), .CONTROL(c64),
    .OUT_VALID(ov64), .OUT_READY(or64),
    .RESULT(res64), .ZEROFLAG(zf64), .NEGFLAG(nf64),
    .CARRYFLAG(cf64), .OVFLAG(of64), .ERRFLAG(ef64)
  );

  seq_alu #(.WIDTH(8)) d8 (
    .CLK(CLK), .RST(RST),
    .IN_VALID(iv8), .IN_READY(ir8),
    .A(a8), .B(b8), .CONTROL(c8),
    .OUT_VALID(ov8), .OUT_READY(or8),
    .RESULT(res8), .ZEROFLAG(zf8), .NEGFLAG(nf8),
    .CARRYFLAG(cf8), .OVFLAG(of8), .ERRFLAG(ef8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go8(input logic [3:0] c,
                     input logic [7:0] a,
                     input logic [7:0] b);
    @(negedge CLK);
    chk("ir8_before_accept", 64'(ir8), 64'd1);
    iv8 = 1'b1;
    c8  = c;
    a8  = a;
    b8  = b;
    @(posedge CLK);
    #1;
    iv8 = 1'b0;
    a8  = 8'h55;
    b8  = 8'h55;
    c8  = 4'h0;
  endtask

  task automatic rel8();
    or8 = 1'b1;
    @(posedge CLK);
    #1;
    or8 = 1'b0;
    @(negedge CLK);
    chk("ov8_cleared", 64'(ov8), 64'd0);
  endtask

  task automatic run8(input string tag,
                      input logic [3:0] c,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] r,
                      input logic [4:0] f);
    go8(c, a, b);
    @(negedge CLK);
    chk({tag, "_valid"}, 64'(ov8), 64'd1);
    chk({tag, "_result"}, 64'(res8), 64'(r));
    chk({tag, "_flags"}, 64'(fl8), 64'(f));
    rel8();
  endtask

  initial begin
    RST  = 1'b1;
    iv64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0; c64 = '0;
    iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; c8  = '0;

    // reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_ir64", 64'(ir64), 64'd0);
    chk("rst_ov64", 64'(ov64), 64'd0);
    chk("rst_res64", res64, 64'd0);
    chk("rst_ir8", 64'(ir8), 64'd0);
    chk("rst_flags8", 64'(fl8), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_ir64", 64'(ir64), 64'd1);
    chk("rel_ir8", 64'(ir8), 64'd1);

    // 64-bit ADD wrap: all-ones + 1
    iv64 = 1'b1;
    c64  = 4'b0010;
    a64  = 64'hFFFF_FFFF_FFFF_FFFF;
    b64  = 64'd1;
    @(posedge CLK);
    #1;
    iv64 = 1'b0;
    a64  = 64'h1234;
    b64  = 64'h5678;
    @(negedge CLK);
    chk("add64_valid", 64'(ov64), 64'd1);
    chk("add64_result", res64, 64'd0);
    chk("add64_zf", 64'(zf64), 64'd1);
    chk("add64_cf", 64'(cf64), 64'd1);
    chk("add64_of", 64'(of64), 64'd0);
    chk("add64_ir", 64'(ir64), 64'd0);
    or64 = 1'b1;
    @(posedge CLK);
    #1;
    or64 = 1'b0;
    @(negedge CLK);
    chk("add64_ov_clr", 64'(ov64), 64'd0);
    chk("add64_ir_back", 64'(ir64), 64'd1);

    // 8-bit directed vectors; flags are {Z,N,C,V,E}
    run8("sub_ovf", 4'b0110, 8'h80, 8'h01, 8'h7F, 5'b00110);
    run8("sub_brw", 4'b0110, 8'h01, 8'h02, 8'hFF, 5'b01000);
    run8("sub_eq",  4'b0110, 8'h33, 8'h33, 8'h00, 5'b10100);
    run8("add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 5'b01010);
    run8("sra3",    4'b0101, 8'h90, 8'hF3, 8'hF2, 5'b01000);
    run8("sll3",    4'b0011, 8'h90, 8'hF3, 8'h80, 5'b01000);
    run8("srl3",    4'b0100, 8'h90, 8'hF3, 8'h12, 5'b00000);
    run8("sra0",    4'b0101, 8'h90, 8'h08, 8'h90, 5'b01000);
    run8("and",     4'b0000, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    run8("or",      4'b0001, 8'hF0, 8'h0C, 8'hFC, 5'b01000);
    run8("nor",     4'b1100, 8'hF0, 8'h0C, 8'h03, 5'b00000);
    run8("passb",   4'b0111, 8'hA5, 8'h5A, 8'h5A, 5'b00000);

    // illegal opcode, then hold OUT_READY low
    go8(4'b1111, 8'h12, 8'h34);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("ill_valid", 64'(ov8), 64'd1);
      chk("ill_result", 64'(res8), 64'd0);
      chk("ill_flags", 64'(fl8), 64'(5'b10001));
    end
    rel8();
    chk("ill_ir_back", 64'(ir8), 64'd1);

    // MUL 13*11 = 143: busy for 9 edges, valid after the 9th
    go8(4'b1000, 8'h0D, 8'h0B);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      chk("mul_busy", 64'({ov8, ir8}), 64'd0);
    end
    @(negedge CLK);
    chk("mul_valid", 64'(ov8), 64'd1);
    chk("mul_result", 64'(res8), 64'h8F);
    chk("mul_flags", 64'(fl8), 64'(5'b01000));
    rel8();

    // reset mid-multiply aborts immediately
    go8(4'b1000, 8'h0D, 8'h0B);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_result", 64'(res8), 64'd0);
    chk("abort_valid", 64'(ov8), 64'd0);
    chk("abort_ir", 64'(ir8), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    run8("add_post", 4'b0010, 8'h02, 8'h03, 8'h05, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the datapath's combinational 64-bit ALU.
- Registers every result and flag behind a valid/ready interface.
- Adds shifts, signed-overflow/carry/negative flags and an iterative shift-add multiplier.
- Sits between the register-read stage and writeback. The execute stage stalls on IN_READY and OUT_VALID.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), derived; shift-amount width taken from B[SHW-1:0].

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operation request
- IN_READY  output  1  block can accept a request this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B / shift amount
- CONTROL  input  4  operation select
- OUT_VALID  output  1  RESULT/flags valid
- OUT_READY  input  1  consumer takes result
- RESULT  output  WIDTH  registered result
- ZEROFLAG  output  1  RESULT == 0
- NEGFLAG  output  1  RESULT[WIDTH-1]
- CARRYFLAG  output  1  ADD carry-out; SUB no-borrow (A >= B unsigned); 0 otherwise
- OVFLAG  output  1  signed overflow for ADD/SUB; 0 otherwise
- ERRFLAG  output  1  illegal CONTROL code

Behaviour:
- Reset: RST high asynchronously forces state IDLE and clears the following to 0:
  - RESULT and all flags, OUT_VALID
  - the multiply counter and accumulator
- IN_READY is 0 while RST is high and 1 in the cycle after release.
- Opcodes (CONTROL):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B, 1100 NOR
  - 0011 SLL, 0100 SRL, 0101 SRA: amount is B[SHW-1:0], upper B bits ignored
  - 1000 MUL: low WIDTH bits of A*B, unsigned (identical for signed two's complement)
- Illegal opcode: RESULT=0, ERRFLAG=1, ZEROFLAG=1, other flags 0. Latency is single-cycle. No X is ever driven.
- Arithmetic: ADD and SUB are computed in WIDTH+1 bits.
  - CARRYFLAG = bit WIDTH of A+B, or of A+~B+1.
  - OVFLAG = operands' sign bits agree (after inverting B for SUB) and RESULT's sign differs.
- States: IDLE, MUL, DONE.
- IN_READY = (state == IDLE). A request is accepted on a rising edge with IN_VALID && IN_READY. A, B and CONTROL are sampled only at acceptance; later input changes have no effect.
- Non-MUL ops from IDLE: the result and flags are registered at the accept edge and the state goes to DONE. Latency is 1: OUT_VALID is high in the cycle after the accept edge.
- MUL from IDLE: latch A into a shift register and B into a multiplier register; clear the accumulator and counter; go to MUL.
  - In MUL, each edge adds the shifted A if the current B bit is 1, shifts, and increments the counter.
  - After WIDTH iterations go to DONE. Latency is WIDTH+1 edges from the accept edge.
  - MUL flags: ZEROFLAG and NEGFLAG from RESULT; CARRYFLAG=OVFLAG=ERRFLAG=0.
- DONE: OUT_VALID=1. RESULT and flags are held stable until an edge with OUT_READY=1, then the state returns to IDLE (OUT_VALID=0).
  - There is no same-cycle new accept. Back-to-back throughput is one op per 2 cycles.
- OUT_READY is ignored outside DONE. IN_VALID is ignored outside IDLE; the requester must hold it.
- Reset in MUL or DONE aborts the operation. The partial result is discarded and is not presented.
- Shift by 0 returns A unchanged. SRA replicates A[WIDTH-1].

Test Plan:
- Reset, then WIDTH=64, ADD A=0xFFFFFFFFFFFFFFFF B=1 -> one cycle later OUT_VALID=1, RESULT=0, ZEROFLAG=1, CARRYFLAG=1, OVFLAG=0.
- WIDTH=8, SUB A=0x80 B=0x01 -> RESULT=0x7F, OVFLAG=1, CARRYFLAG=1, NEGFLAG=0.
- WIDTH=8, MUL A=0x0D B=0x0B -> OUT_VALID exactly 9 edges after accept, RESULT=0x8F. IN_READY=0 throughout.
- WIDTH=8, SRA A=0x90 B=0xF3 (amount 3) -> RESULT=0xF2, NEGFLAG=1. SLL same operands -> RESULT=0x80.
- CONTROL=1111 -> RESULT=0, ERRFLAG=1. Hold OUT_READY=0 for 5 cycles -> RESULT/flags stable, OUT_VALID stays 1. Raise OUT_READY -> IDLE next edge.
- Start MUL, assert RST mid-iteration (between edges) -> outputs 0 immediately. After release, an ADD 2+3 returns RESULT=5 with latency 1.
